frame_writer: RTL and testbench

//  Write-side counterpart of the frame reader: captures one 6144-bit frame and stores it to external
//  RAM as BEATS consecutive 768-bit beats through a pulse/ready write port. Frames go to a ring of
//  BUF_FRAMES frame slots; the slot index advances after each completed frame. Sits between the

---
 rtl/frame_writer.sv | 150 +++++++++++++++
 tb/tb_frame_writer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/frame_writer.sv
// frame_writer: captures one frame from the producer and streams it to external
// RAM as BEATS consecutive beats over a strobe/ready write port. Frames land in a
// ring of BUF_FRAMES slots; the slot advances only after a fully written frame.
module frame_writer #(
  parameter int          FRAME_W    = 6144,
  parameter int          BEAT_W     = 768,
  parameter int          BEATS      = 8,
  parameter int          ADDR_W     = 32,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned ADDR_STEP  = 96,
  parameter int          BUF_FRAMES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ram_init,
  input  logic               phy_init_done,
  input  logic [FRAME_W-1:0] write_data,
  input  logic               send_data,
  output logic               ram_ack,
  output logic               busy,
  output logic               write_out,
  output logic [ADDR_W-1:0]  w_address_out,
  output logic [BEAT_W-1:0]  w_data_out,
  input  logic               ready
);

  localparam int BEAT_IW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SLOT_IW = (BUF_FRAMES > 1) ? $clog2(BUF_FRAMES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_reg, state_next;
  logic [BEAT_IW-1:0]   beat_reg, beat_next;
  logic [SLOT_IW-1:0]   slot_reg, slot_next;
  logic [FRAME_W-1:0]   frame_reg;
  logic [ADDR_W-1:0]    addr_reg;
  logic [BEAT_W-1:0]    data_reg;
  logic                 ram_ack_reg;
  logic                 capture;
  logic                 init_ok;
  logic [FRAME_W-1:0]   frame_src;
  logic [BEAT_W-1:0]    beat_words [BEATS];
  logic [ADDR_W-1:0]    addr_calc;

  assign init_ok = ram_init & phy_init_done;

  // While idle the first beat comes straight from the input bus, because the
  // frame register is loaded on the same edge that launches beat 0.
  assign frame_src = (state_reg == IDLE) ? write_data : frame_reg;

  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_beat
      assign beat_words[gi] = frame_src[gi*BEAT_W +: BEAT_W];
    end
  endgenerate

  // Beat address for the beat about to be issued, wrapping mod 2^ADDR_W.
  assign addr_calc = ADDR_W'(BASE_ADDR)
                   + (ADDR_W'(slot_reg) * ADDR_W'(BEATS) + ADDR_W'(beat_next))
                   * ADDR_W'(ADDR_STEP);

  // Next-state, beat and slot sequencing; init loss aborts an active frame.
  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    slot_next  = slot_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (send_data && init_ok) begin
          state_next = ISSUE;
          beat_next  = '0;
          capture    = 1'b1;
        end
      end
      ISSUE: begin
        if (!init_ok) begin
          state_next = IDLE;
          beat_next  = '0;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (!init_ok) begin
          state_next = IDLE;
          beat_next  = '0;
        end else if (ready) begin
          if (beat_reg == BEAT_IW'(BEATS - 1)) begin
            state_next = DONE;
          end else begin
            beat_next  = beat_reg + BEAT_IW'(1);
            state_next = ISSUE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        beat_next  = '0;
        slot_next  = (slot_reg == SLOT_IW'(BUF_FRAMES - 1)) ? '0 : slot_reg + SLOT_IW'(1);
      end
      default: begin
        state_next = IDLE;
        beat_next  = '0;
      end
    endcase
  end

  // State, counters, captured frame and the held address/data of the current beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      beat_reg    <= '0;
      slot_reg    <= '0;
      frame_reg   <= '0;
      addr_reg    <= '0;
      data_reg    <= '0;
      ram_ack_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      slot_reg  <= slot_next;
      if (capture) begin
        frame_reg <= write_data;
      end
      // Address/data change only when a beat is launched, so they stay
      // stable through WAIT and after the frame ends.
      if (state_next == ISSUE) begin
        addr_reg <= addr_calc;
        data_reg <= beat_words[beat_next];
      end
      // The acknowledge follows the DONE cycle, landing two cycles after
      // the final ready.
      ram_ack_reg <= (state_reg == DONE);
    end
  end

  assign write_out     = (state_reg == ISSUE);
  assign busy          = (state_reg != IDLE);
  assign ram_ack       = ram_ack_reg;
  assign w_address_out = addr_reg;
  assign w_data_out    = data_reg;

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer: two instances (4-slot and 2-slot rings)
// share all inputs so ring wrap can be observed alongside the default ring.
module tb_frame_writer;

  localparam int FRAME_W = 6144;
  localparam int BEAT_W  = 768;
  localparam int BEATS   = 8;
  localparam int ADDR_W  = 32;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               ram_init = 1'b0;
  logic               phy_init_done = 1'b0;
  logic [FRAME_W-1:0] write_data = '0;
  logic               send_data = 1'b0;
  logic               ready = 1'b0;

  logic               ram_ack_a, busy_a, write_out_a;
  logic [ADDR_W-1:0]  w_address_out_a;
  logic [BEAT_W-1:0]  w_data_out_a;
  logic               ram_ack_b, busy_b, write_out_b;
  logic [ADDR_W-1:0]  w_address_out_b;
  logic [BEAT_W-1:0]  w_data_out_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_writer #(.BUF_FRAMES(4)) dut_a (
    .clk(clk), .reset(reset), .ram_init(ram_init), .phy_init_done(phy_init_done),
    .write_data(write_data), .send_data(send_data), .ram_ack(ram_ack_a), .busy(busy_a),
    .write_out(write_out_a), .w_address_out(w_address_out_a), .w_data_out(w_data_out_a),
    .ready(ready)
  );

  frame_writer #(.BUF_FRAMES(2)) dut_b (
    .clk(clk), .reset(reset), .ram_init(ram_init), .phy_init_done(phy_init_done),
    .write_data(write_data), .send_data(send_data), .ram_ack(ram_ack_b), .busy(busy_b),
    .write_out(write_out_b), .w_address_out(w_address_out_b), .w_data_out(w_data_out_b),
    .ready(ready)
  );

  task automatic check(input string tag, input logic [767:0] got, input logic [767:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FRAME_W-1:0] mk_frame(input logic [767:0] first);
    logic [FRAME_W-1:0] f;
    for (int k = 0; k < BEATS; k++) f[k*BEAT_W +: BEAT_W] = first + 768'(k);
    return f;
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy_a"}, 768'(busy_a), 768'(0));
    check({tag, "_busy_b"}, 768'(busy_b), 768'(0));
    check({tag, "_wr_a"},   768'(write_out_a), 768'(0));
    check({tag, "_ack_a"},  768'(ram_ack_a), 768'(0));
    check({tag, "_addr_a"}, 768'(w_address_out_a), 768'(0));
    check({tag, "_addr_b"}, 768'(w_address_out_b), 768'(0));
    check({tag, "_data_a"}, w_data_out_a, 768'(0));
  endtask

  // mode 0 normal, 1 drop ram_init in WAIT of beat `at`, 2 reset in WAIT of
  // beat `at`, 3 inject send_data / write_data changes during each WAIT.
  task automatic run_frame(input logic [FRAME_W-1:0] d, input logic [31:0] base_a,
                           input logic [31:0] base_b, input int mode, input int at);
    logic [31:0] ea, eb;
    write_data = d;
    send_data  = 1'b1;
    tick();
    send_data  = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      ea = base_a + 32'(k * 96);
      eb = base_b + 32'(k * 96);
      check("wr_a", 768'(write_out_a), 768'(1));
      check("wr_b", 768'(write_out_b), 768'(1));
      check("addr_a", 768'(w_address_out_a), 768'(ea));
      check("addr_b", 768'(w_address_out_b), 768'(eb));
      check("data_a", w_data_out_a, d[k*BEAT_W +: BEAT_W]);
      check("data_b", w_data_out_b, d[k*BEAT_W +: BEAT_W]);
      tick();
      check("wr_pulse", 768'(write_out_a), 768'(0));
      if (mode == 3) begin
        write_data = ~d;
        send_data  = 1'b1;
        tick();
        send_data  = 1'b0;
      end
      if (mode == 1 && k == at) begin
        ram_init = 1'b0;
        tick();
        check("abort_busy_a", 768'(busy_a), 768'(0));
        check("abort_busy_b", 768'(busy_b), 768'(0));
        ram_init = 1'b1;
        for (int c = 0; c < 4; c++) begin
          tick();
          check("abort_wr", 768'(write_out_a), 768'(0));
          check("abort_ack", 768'(ram_ack_a | ram_ack_b), 768'(0));
        end
        return;
      end
      if (mode == 2 && k == at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_zero("midrst");
        return;
      end
      repeat (19) tick();
      check("hold_addr", 768'(w_address_out_a), 768'(ea));
      check("hold_wr", 768'(write_out_a), 768'(0));
      ready = 1'b1;
      tick();
      ready = 1'b0;
    end
    // Cycle after the last ready: DONE, no ack yet.
    check("done_ack", 768'(ram_ack_a), 768'(0));
    check("done_busy", 768'(busy_a), 768'(1));
    tick();
    check("ack_a", 768'(ram_ack_a), 768'(1));
    check("ack_b", 768'(ram_ack_b), 768'(1));
    check("busy_fall", 768'(busy_a), 768'(0));
    tick();
    check("ack_pulse", 768'(ram_ack_a), 768'(0));
    check("idle_wr", 768'(write_out_a), 768'(0));
    $display("frame base_a=%0d base_b=%0d mode=%0d done", base_a, base_b, mode);
  endtask

  initial begin
    // Reset, with a send_data request that reset must override.
    send_data = 1'b1;
    ram_init = 1'b1;
    phy_init_done = 1'b1;
    write_data = mk_frame(768'd1);
    repeat (3) tick();
    send_data = 1'b0;
    reset = 1'b0;
    check_idle_zero("reset");
    tick();
    check("post_reset_wr", 768'(write_out_a), 768'(0));
    $display("reset checked");

    // Frames 1-3: 4-slot ring advances, 2-slot ring wraps on the third.
    run_frame(mk_frame(768'd1), 32'd0,    32'd0,   0, 0);
    run_frame(mk_frame(768'd1), 32'd768,  32'd768, 0, 0);
    run_frame(mk_frame(768'd1), 32'd1536, 32'd0,   0, 0);

    // Request without PHY init is dropped.
    phy_init_done = 1'b0;
    send_data = 1'b1;
    tick();
    send_data = 1'b0;
    check("noinit_wr", 768'(write_out_a), 768'(0));
    check("noinit_busy", 768'(busy_a), 768'(0));
    repeat (3) tick();
    check("noinit_ack", 768'(ram_ack_a), 768'(0));
    phy_init_done = 1'b1;
    // ready while idle does nothing.
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("idle_ready_wr", 768'(write_out_a), 768'(0));
    check("idle_ready_busy", 768'(busy_a), 768'(0));
    $display("dropped request and idle ready checked");

    // Noisy frame: extra requests and a changed write_data bus while active.
    run_frame(mk_frame(768'h5a00), 32'd2304, 32'd768, 3, 0);

    // Init loss in WAIT of beat 3, then the same slot is reused.
    run_frame(mk_frame(768'h700), 32'd0, 32'd0, 1, 3);
    $display("init-loss abort checked");
    run_frame(mk_frame(768'h900), 32'd0, 32'd0, 0, 0);

    // Reset in WAIT of beat 5 returns both rings to slot 0.
    run_frame(mk_frame(768'hb00), 32'd768, 32'd768, 2, 5);
    $display("mid-frame reset checked");
    run_frame(mk_frame(768'hc00), 32'd0, 32'd0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
